// File: rtl/fdiv_pkg.sv
// Shared constants and types for the multi-cycle divider slice.
package fdiv_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECIP = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0]  EXP_INF      = 8'hFF;
  localparam logic [7:0]  EXP_ZERO     = 8'h00;
  localparam logic [7:0]  EXP_FINV_MAX = 8'd253;
  localparam logic [31:0] POS_INF      = 32'h7F80_0000;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_OVF  = 2'd1,
    CLS_ZERO = 2'd2,
    CLS_UNF  = 2'd3
  } cls_t;

  function automatic logic [31:0] signed_inf(input logic sgn);
    return POS_INF | {sgn, 31'h0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic sgn);
    return {sgn, 31'h0};
  endfunction

endpackage

// File: rtl/fdiv_special.sv
// Operand classifier: picks the special-case class and its forced quotient.
module fdiv_special
  import fdiv_pkg::*;
(
  input  logic [31:0] s,
  input  logic [31:0] t,
  output cls_t        cls,
  output logic [31:0] forced
);

  logic       sgn;
  logic [7:0] es;
  logic [7:0] et;

  assign sgn = s[31] ^ t[31];
  assign es  = s[30:23];
  assign et  = t[30:23];

  always_comb begin
    cls    = CLS_NONE;
    forced = signed_zero(sgn);
    if (et == EXP_ZERO || es == EXP_INF || et == EXP_INF) begin
      cls    = CLS_OVF;
      forced = signed_inf(sgn);
    end else if (es == EXP_ZERO) begin
      cls = CLS_ZERO;
    end else if (et > EXP_FINV_MAX) begin
      cls = CLS_UNF;
    end
  end

endmodule

// File: rtl/finv.sv
// Combinational reciprocal of a normal single, round-to-nearest-even.
module finv (
  input  logic [31:0] x,
  output logic [31:0] y
);

  localparam logic [49:0] ONE_49 = 50'h1 << 49;

  logic [26:0] q;
  logic [23:0] r;
  logic [22:0] frac_pre;
  logic [22:0] frac_r;
  logic        g, st, inc, carry;
  logic [7:0]  exp_base;

  always_comb begin
    q = 27'(ONE_49 / {26'd0, 1'b1, x[22:0]});
    r = 24'(ONE_49 % {26'd0, 1'b1, x[22:0]});
    // q[26] only when the mantissa is exactly 1.0, giving an exact power of two
    if (q[26]) begin
      frac_pre = q[25:3];
      g        = q[2];
      st       = (|q[1:0]) | (|r);
      exp_base = 8'd254 - x[30:23];
    end else begin
      frac_pre = q[24:2];
      g        = q[1];
      st       = q[0] | (|r);
      exp_base = 8'd253 - x[30:23];
    end
    inc             = g & (st | frac_pre[0]);
    {carry, frac_r} = {1'b0, frac_pre} + {23'd0, inc};
    y               = {x[31], exp_base + {7'd0, carry}, frac_r};
  end

endmodule

// File: rtl/fmul.sv
// Combinational single multiply, round-to-nearest-even, saturating to inf, flushing to zero.
module fmul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [47:0] p;
  logic [22:0] frac_pre;
  logic [22:0] frac_r;
  logic        g, st, inc, carry, sgn;
  logic [9:0]  eu;

  always_comb begin
    sgn = a[31] ^ b[31];
    p   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (p[47]) begin
      frac_pre = p[46:24];
      g        = p[23];
      st       = |p[22:0];
    end else begin
      frac_pre = p[45:23];
      g        = p[22];
      st       = |p[21:0];
    end
    inc             = g & (st | frac_pre[0]);
    {carry, frac_r} = {1'b0, frac_pre} + {23'd0, inc};
    // eu carries the +127 bias once more than the final exponent
    eu = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'd0, p[47]} + {9'd0, carry};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || eu <= 10'd127)
      y = {sgn, 31'h0};
    else if (eu >= 10'd382)
      y = {sgn, 8'hFF, 23'h0};
    else
      y = {sgn, 8'(eu - 10'd127), frac_r};
  end

endmodule

// File: rtl/fdiv_mc.sv
// Multi-cycle divider q = s / t built from finv and fmul captured after fixed waits.
module fdiv_mc
  import fdiv_pkg::*;
#(
  parameter int FINV_WAIT = 4,
  parameter int FMUL_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow
);

  localparam int MAX_WAIT = (FINV_WAIT > FMUL_WAIT) ? FINV_WAIT : FMUL_WAIT;
  localparam int CW       = $clog2(MAX_WAIT) + 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   s_r, t_r, inv_r, forced_r;
  logic [31:0]   recip, prod, forced, d_next;
  cls_t          cls, cls_r;
  logic          sgn, ovf_next, unf_next;

  fdiv_special u_special (.s(s), .t(t), .cls(cls), .forced(forced));
  finv         u_finv    (.x(t_r), .y(recip));
  fmul         u_fmul    (.a(s_r), .b(inv_r), .y(prod));

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign sgn       = s_r[31] ^ t_r[31];

  always_comb begin
    d_next   = prod;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    case (cls_r)
      CLS_OVF:  begin d_next = forced_r; ovf_next = 1'b1; end
      CLS_ZERO: d_next = forced_r;
      CLS_UNF:  begin d_next = forced_r; unf_next = 1'b1; end
      default: begin
        if (prod[30:23] == EXP_INF) begin
          d_next   = signed_inf(sgn);
          ovf_next = 1'b1;
        end else if (prod[30:23] == EXP_ZERO) begin
          d_next   = signed_zero(sgn);
          unf_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      s_r       <= '0;
      t_r       <= '0;
      inv_r     <= '0;
      forced_r  <= '0;
      cls_r     <= CLS_NONE;
      d         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s_r      <= s;
          t_r      <= t;
          cls_r    <= cls;
          forced_r <= forced;
          cnt      <= CW'(FINV_WAIT - 1);
          state    <= RECIP;
        end
        RECIP: if (cnt == '0) begin
          inv_r <= recip;
          cnt   <= CW'(FMUL_WAIT - 1);
          state <= MUL;
        end else begin
          cnt <= cnt - CW'(1);
        end
        MUL: if (cnt == '0) begin
          d         <= d_next;
          overflow  <= ovf_next;
          underflow <= unf_next;
          state     <= DONE;
        end else begin
          cnt <= cnt - CW'(1);
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_mc.sv
// Bench for fdiv_mc: directed corner cases plus random traffic against a real-arithmetic model.
module tb_fdiv_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] s = '0;
  logic [31:0] t = '0;
  logic        in_ready, out_valid, overflow, underflow;
  logic [31:0] d;

  fdiv_mc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        ovf;
    logic        unf;
    int          acc;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_res = 0;
  int          ready_mode = 0;
  bit          seen = 0;
  logic [31:0] held_d;
  logic [1:0]  held_f;

  task automatic chk_cond(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    chk_cond(nm, act === req, act, req);
  endtask

  function automatic real to_real(input logic [31:0] f);
    logic [10:0] e11;
    e11 = {3'b0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e11, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] b;
    logic [23:0] fr;
    int          e;
    b  = $realtobits(r);
    e  = int'(b[62:52]) - 1023 + 127;
    fr = {1'b0, b[51:29]} + {23'd0, b[28] & ((|b[27:0]) | b[29])};
    if (fr[23]) e++;
    if (e >= 255) return {b[63], 8'hFF, 23'h0};
    if (e <= 0)   return {b[63], 31'h0};
    return {b[63], 8'(e), fr[22:0]};
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic        sg;
    logic [31:0] f;
    sg    = a[31] ^ b[31];
    e.d   = {sg, 31'h0};
    e.ovf = 1'b0;
    e.unf = 1'b0;
    e.acc = 0;
    if (b[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      e.d = {sg, 8'hFF, 23'h0}; e.ovf = 1'b1;
    end else if (a[30:23] == 8'h00) begin
      e.d = {sg, 31'h0};
    end else if (b[30:23] >= 8'd254) begin
      e.unf = 1'b1;
    end else begin
      f = to_f32(to_real(a) / to_real(b));
      if (f[30:23] == 8'hFF) begin e.d = {sg, 8'hFF, 23'h0}; e.ovf = 1'b1; end
      else if (f[30:23] == 8'h00) e.unf = 1'b1;
      else e.d = f;
    end
    return e;
  endfunction

  function automatic bit within_ulp(input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    ia = int'(a[30:0]);
    ib = int'(b[30:0]);
    return (a[31] == b[31]) && (ia - ib <= 1) && (ib - ia <= 1);
  endfunction

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Single compare process: latency, value, hold stability and ordering per result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_acc -= expq.size();
      expq.delete();
      seen = 0;
    end else begin
      if (in_valid && in_ready) begin
        e     = model(s, t);
        e.acc = cyc + 1;
        expq.push_back(e);
        n_acc++;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk_cond("spurious_out", 1'b0, d, 32'h0);
        end else if (!seen) begin
          e      = expq[0];
          seen   = 1;
          held_d = d;
          held_f = {overflow, underflow};
          chk("latency", 32'(cyc - e.acc), 32'd6);
          chk("flags", {30'd0, overflow, underflow}, {30'd0, e.ovf, e.unf});
          if (e.d[30:23] != 8'h00 && e.d[30:23] != 8'hFF)
            chk_cond("quotient_ulp", within_ulp(d, e.d), d, e.d);
          else
            chk("quotient", d, e.d);
        end else begin
          chk("hold_d", d, held_d);
          chk("hold_flags", {30'd0, overflow, underflow}, {30'd0, held_f});
        end
        if (out_ready && expq.size() != 0) begin
          void'(expq.pop_front());
          seen = 0;
          n_res++;
        end
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk_cond("accept_timeout", 1'b0, 32'd0, 32'd1);
    else begin
      s = a; t = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; s = $urandom; t = $urandom;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk_cond("valid_timeout", 1'b0, 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk_cond("idle_timeout", 1'b0, 32'd0, 32'd1);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d", d, 32'h0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_d", d, 32'h0);
    chk("reset_flags", {30'd0, overflow, underflow}, 32'd0);

    chk("model_6_2", model(32'h40C00000, 32'h40000000).d, 32'h40400000);
    chk("model_1_3", model(32'h3F800000, 32'h40400000).d, 32'h3EAAAAAB);
    chk("model_div0", model(32'h40400000, 32'h00000000).d, 32'h7F800000);
    chk("model_0_m5", model(32'h00000000, 32'hC0A00000).d, 32'h80000000);
    chk("model_unf", {31'd0, model(32'h3F800000, 32'h7F000000).unf}, 32'd1);

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    ready_mode = 0;
    do_op(32'h40C00000, 32'h40000000);
    wait_valid();
    chk("d_6_over_2", d, 32'h40400000);
    chk("flags_6_over_2", {30'd0, overflow, underflow}, 32'd0);
    wait_idle();

    ready_mode = 2;
    do_op(32'h3F800000, 32'hC0800000);
    wait_valid();
    chk("d_1_over_m4", d, 32'hBE800000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; s = $urandom; t = $urandom;
      @(posedge clk); #1;
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_d_literal", d, 32'hBE800000);
    end
    in_valid = 1'b0;
    ready_mode = 0;
    wait_idle();

    do_op(32'h00000000, 32'hC0A00000);
    wait_valid();
    chk("d_0_over_m5", d, 32'h80000000);
    chk("flags_0_over_m5", {30'd0, overflow, underflow}, 32'd0);
    wait_idle();

    do_op(32'h3F800000, 32'h7F000000);
    wait_valid();
    chk("d_finv_wrap", d, 32'h00000000);
    chk("unf_finv_wrap", {31'd0, underflow}, 32'd1);
    wait_idle();

    do_op(32'h40400000, 32'h00000000);
    wait_valid();
    chk("d_3_over_0", d, 32'h7F800000);
    chk("ovf_3_over_0", {30'd0, overflow, underflow}, 32'd2);
    wait_idle();

    do_op(32'h3F800000, 32'h40000000);
    @(posedge clk); #1;
    pulse_rst();
    ready_mode = 2;
    do_op(32'h40C00000, 32'h40000000);
    wait_valid();
    pulse_rst();
    ready_mode = 0;
    do_op(32'h3F800000, 32'h3F800000);
    wait_valid();
    chk("d_after_rst", d, 32'h3F800000);
    wait_idle();

    ready_mode = 1;
    for (int i = 0; i < 1000; i++) do_op(rnd_norm(), rnd_norm());
    for (int n = 0; n < 200 && expq.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("pending_results", 32'(expq.size()), 32'd0);
    chk("one_result_per_accept", 32'(n_res), 32'(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
